hex_display_arbiter: RTL and testbench
======================================

HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 8, giving the minimum number of clock cycles a grant is held (legal range 1..255).
REQ-002 The block SHALL have parameter BLANK_SEG, default 8'hFF, giving the segment pattern driven when no requester is granted (active-low, all segments off).
REQ-003 ADC_CLK_10  input  1  the single clock; every flop samples on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  3  per-requester display request; bit i belongs to requester i.
REQ-006 data0, data1, data2  input  24 each  six 4-bit hex digits per requester; bits [3:0] map to HEX0 and bits [23:20] map to HEX5.
REQ-007 dp  input  6  decimal-point enables for the granted requester's digits, active-high; bit k maps to HEXk.
REQ-008 pause  input  1  active-high; while high, the hold counter is frozen.
REQ-009 grant  output  3  one-hot grant, registered; all zeros when idle.
REQ-010 busy  output  1  high whenever grant is nonzero.
REQ-011 HEX0..HEX5  output  8 each  active-low 7-segment outputs; bit 7 is the decimal point and bits 6:0 are segments g..a.

Function
REQ-012 The arbiter SHALL have two states: IDLE and GRANTED.
REQ-013 In IDLE, on an edge where req != 0, the arbiter SHALL move to GRANTED and grant the first requesting index after last_grant, searching round-robin.
REQ-014 The last_grant pointer SHALL reset to 2, so that requester 0 has first priority after reset.
REQ-015 On entry to GRANTED, hold_cnt SHALL load HOLD_CYCLES-1.
REQ-016 In GRANTED, hold_cnt SHALL decrement each cycle while pause=0 and hold_cnt>0, and SHALL hold its value while pause=1.
REQ-017 In GRANTED with hold_cnt>0, the grant SHALL NOT change, even if the granted requester drops req or other requesters assert.
REQ-018 In GRANTED with hold_cnt==0 and pause=0, if another requester is asserting, the arbiter SHALL grant the next one round-robin and reload hold_cnt.
REQ-019 In GRANTED with hold_cnt==0 and pause=0, if only the current requester is asserting, the arbiter SHALL keep the grant and reload hold_cnt.
REQ-020 In GRANTED with hold_cnt==0 and pause=0, if no requester is asserting, the arbiter SHALL go to IDLE, drive grant=0, and update last_grant to the released index.
REQ-021 In GRANTED with hold_cnt==0 and pause=1, the grant SHALL NOT change.
REQ-022 A 24-bit display register and a 6-bit dp register SHALL load from the next-granted requester's data and from dp on every edge where the next state is GRANTED, so that HEX changes on the same edge as grant (latency 1 cycle from req or data change).
REQ-023 While the granted requester holds req low during its hold window, its data SHALL still be loaded live.
REQ-024 In IDLE, all HEX outputs SHALL equal BLANK_SEG.
REQ-025 Each digit SHALL be decoded to the standard hex glyphs 0-9 and A-F (for example 0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E).
REQ-026 HEX[7] SHALL equal ~dp_reg[k] for digit k.
REQ-027 busy SHALL equal |grant, and grant SHALL never have more than one bit set.

Reset
REQ-028 While reset=1, the block SHALL asynchronously force: state=IDLE, grant=0, busy=0, hold_cnt=0, last_grant=2, display register=0, dp register=0, all HEX=BLANK_SEG.
REQ-029 A reset asserted mid-grant SHALL abort that grant immediately.
REQ-030 After reset deassertion, the first edge SHALL behave as in IDLE.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE, GRANTED), the 16-entry glyph table, and the constant NUM_REQ=3.
REQ-032 Digit decoding SHALL be implemented in a combinational sub-module, seg7_decode (4-bit digit plus dp in, 8-bit segment out), instantiated six times.

Verification
REQ-033 Reset with req=0 -> grant=000, busy=0, and every HEX=8'hFF; asserting reset mid-grant returns the block to this state without waiting for a clock edge.
REQ-034 req=001, data0=24'h012345 -> after 1 edge grant=001, HEX0=8'h92 ("5"), HEX5=8'hC0 ("0").
REQ-035 req=011 held, HOLD_CYCLES=8 -> grant alternates 001 and 010 every 8 cycles, with no gap cycle.
REQ-036 Grant on requester 0, which drops req after 2 cycles while req=100 is asserted -> grant=001 persists for 8 cycles total, then grant=100 on the next edge.
REQ-037 pause=1 for 5 cycles during a grant -> that grant lasts 13 cycles.
REQ-038 All req deasserted with hold expired -> IDLE; a subsequent req=111 grants the index after the last released one.

Source files
------------

// File: rtl/hex_display_arbiter_pkg.sv
// Shared definitions for the hex display arbiter: FSM encoding, requester
// count and the active-low 7-segment glyph table (bit order g..a).
package hex_display_arbiter_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_display_if.sv
// Requester-side bus of the hex display arbiter plus its display outputs.
// req[i] is a level request. grant is one-hot and is held for at least
// HOLD_CYCLES cycles regardless of req. busy tracks |grant.
interface hex_display_if;
  import hex_display_arbiter_pkg::*;

  logic [2:0]  req;
  logic [23:0] data0;
  logic [23:0] data1;
  logic [23:0] data2;
  logic [5:0]  dp;
  logic        pause;
  logic [2:0]  grant;
  logic        busy;
  logic [7:0]  HEX0;
  logic [7:0]  HEX1;
  logic [7:0]  HEX2;
  logic [7:0]  HEX3;
  logic [7:0]  HEX4;
  logic [7:0]  HEX5;
  state_t      dbg_state;

  modport master (
    output req, data0, data1, data2, dp, pause,
    input  grant, busy, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, dbg_state
  );

  modport slave (
    input  req, data0, data1, data2, dp, pause,
    output grant, busy, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, dbg_state
  );

endinterface

// File: rtl/hex_display_arbiter_seg7_decode.sv
// Combinational hex digit to active-low 7-segment decoder with decimal point.
module seg7_decode
  import hex_display_arbiter_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  assign o_seg = {~i_dp, GLYPH[i_digit]};

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter granting one of three requesters the six-digit hex
// display, holding each grant for a minimum number of unpaused cycles.
module hex_display_arbiter
  import hex_display_arbiter_pkg::*;
#(
  parameter int         HOLD_CYCLES = 8,
  parameter logic [7:0] BLANK_SEG   = 8'hFF
) (
  input  logic         ADC_CLK_10,
  input  logic         reset,
  hex_display_if.slave bus
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t      r_state;
  logic [2:0]  r_grant;
  logic        r_busy;
  logic [7:0]  r_hold_cnt;
  logic [1:0]  r_last_grant;
  logic [23:0] r_disp;
  logic [5:0]  r_dp;

  logic        w_found;
  logic [1:0]  w_next_idx;
  logic        w_expired;
  logic        w_take;
  logic        w_release;
  logic        w_next_granted;
  logic [1:0]  w_load_idx;
  logic [23:0] w_load_data;
  logic [7:0]  w_seg [6];
  logic        w_blank;

  // While granted, r_last_grant equals the current owner, so one search
  // starting after it serves both IDLE arbitration and hold expiry.
  always_comb begin
    w_found    = 1'b0;
    w_next_idx = 2'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req[(int'(r_last_grant) + k) % NUM_REQ]) begin
        w_found    = 1'b1;
        w_next_idx = 2'((int'(r_last_grant) + k) % NUM_REQ);
      end
    end
  end

  assign w_expired      = (r_state == GRANTED) && (r_hold_cnt == 8'd0) && !bus.pause;
  assign w_take         = w_found && ((r_state == IDLE) || w_expired);
  assign w_release      = w_expired && !w_found;
  assign w_next_granted = w_take || ((r_state == GRANTED) && !w_release);
  assign w_load_idx     = w_take ? w_next_idx : r_last_grant;

  always_comb begin
    case (w_load_idx)
      2'd0:    w_load_data = bus.data0;
      2'd1:    w_load_data = bus.data1;
      default: w_load_data = bus.data2;
    endcase
  end

  always_ff @(posedge ADC_CLK_10 or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= 3'b000;
      r_busy       <= 1'b0;
      r_hold_cnt   <= 8'd0;
      r_last_grant <= 2'd2;
      r_disp       <= 24'd0;
      r_dp         <= 6'd0;
    end else begin
      if (w_take) begin
        r_state      <= GRANTED;
        r_grant      <= 3'b001 << w_next_idx;
        r_busy       <= 1'b1;
        r_hold_cnt   <= HOLD_LOAD;
        r_last_grant <= w_next_idx;
      end else if (w_release) begin
        r_state <= IDLE;
        r_grant <= 3'b000;
        r_busy  <= 1'b0;
      end else if ((r_state == GRANTED) && (r_hold_cnt != 8'd0) && !bus.pause) begin
        r_hold_cnt <= r_hold_cnt - 8'd1;
      end
      // Live load: the owner's data keeps flowing even if it dropped req.
      if (w_next_granted) begin
        r_disp <= w_load_data;
        r_dp   <= bus.dp;
      end
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_digit
    seg7_decode u_dec (
      .i_digit (r_disp[4*g +: 4]),
      .i_dp    (r_dp[g]),
      .o_seg   (w_seg[g])
    );
  end

  assign w_blank       = (r_state == IDLE);
  assign bus.HEX0      = w_blank ? BLANK_SEG : w_seg[0];
  assign bus.HEX1      = w_blank ? BLANK_SEG : w_seg[1];
  assign bus.HEX2      = w_blank ? BLANK_SEG : w_seg[2];
  assign bus.HEX3      = w_blank ? BLANK_SEG : w_seg[3];
  assign bus.HEX4      = w_blank ? BLANK_SEG : w_seg[4];
  assign bus.HEX5      = w_blank ? BLANK_SEG : w_seg[5];
  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter: directed scenarios plus a
// randomized run against a cycle-level behavioural model of the display owner.
module tb_hex_display_arbiter;
  import hex_display_arbiter_pkg::*;

  localparam int H = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  hex_display_if bus ();

  hex_display_arbiter #(.HOLD_CYCLES(H), .BLANK_SEG(8'hFF)) dut (
    .ADC_CLK_10 (clk),
    .reset      (reset),
    .bus        (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] hex_obs [6];
  assign hex_obs[0] = bus.HEX0;
  assign hex_obs[1] = bus.HEX1;
  assign hex_obs[2] = bus.HEX2;
  assign hex_obs[3] = bus.HEX3;
  assign hex_obs[4] = bus.HEX4;
  assign hex_obs[5] = bus.HEX5;

  logic [6:0] glyph_ref [16];
  initial begin
    glyph_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  // reference model: owner index (-1 = nobody), cycles left, last released
  int          m_owner;
  int          m_last;
  int          m_rem;
  logic [23:0] m_disp;
  logic [5:0]  m_dp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input int after, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      if (r[(after + k) % 3]) return (after + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [23:0] data_of(input int idx);
    if (idx == 0) return bus.data0;
    if (idx == 1) return bus.data1;
    return bus.data2;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 2;
    m_rem   = 0;
    m_disp  = '0;
    m_dp    = '0;
  endtask

  task automatic model_step();
    int nxt;
    if (m_owner < 0) begin
      nxt = pick(m_last, bus.req);
      if (nxt >= 0) begin
        m_owner = nxt;
        m_rem   = H - 1;
      end
    end else if (m_rem > 0) begin
      if (!bus.pause) m_rem--;
    end else if (!bus.pause) begin
      nxt = pick(m_owner, bus.req);
      if (nxt >= 0) begin
        m_owner = nxt;
        m_rem   = H - 1;
      end else begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    if (m_owner >= 0) begin
      m_disp = data_of(m_owner);
      m_dp   = bus.dp;
    end
  endtask

  task automatic check_all(input string tag);
    logic [2:0] eg;
    logic [7:0] eh;
    logic [3:0] d;
    eg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(eg));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(eg != 3'b000));
    for (int k = 0; k < 6; k++) begin
      d  = m_disp[4*k +: 4];
      eh = (m_owner < 0) ? 8'hFF : {~m_dp[k], glyph_ref[d]};
      chk($sformatf("%s.hex%0d", tag, k), 32'(hex_obs[k]), 32'(eh));
    end
  endtask

  // driver tasks
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset();
    bus.req   = 3'b000;
    bus.pause = 1'b0;
    reset     = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    bus.req   = 3'b000;
    bus.data0 = 24'h012345;
    bus.data1 = 24'hABCDEF;
    bus.data2 = 24'h89ABCD;
    bus.dp    = 6'b000000;
    bus.pause = 1'b0;
    model_reset();
    #2;
    apply_reset();

    // single requester, basic decode
    bus.req = 3'b001;
    tick("basic");
    chk("basic.hex0_5", 32'(bus.HEX0), 32'h92);
    chk("basic.hex5_0", 32'(bus.HEX5), 32'hC0);

    // asynchronous reset in the middle of a grant
    tick("pre_rst");
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst.grant", 32'(bus.grant), 32'h0);
    chk("async_rst.busy", 32'(bus.busy), 32'h0);
    chk("async_rst.hex0", 32'(bus.HEX0), 32'hFF);
    chk("async_rst.hex5", 32'(bus.HEX5), 32'hFF);
    apply_reset();

    // two requesters alternate every H cycles without a gap
    bus.req = 3'b011;
    for (int i = 0; i < 4 * H; i++) begin
      tick("alt");
      chk("alt.pattern", 32'(bus.grant), ((i / H) % 2 == 0) ? 32'h1 : 32'h2);
    end

    // owner drops req early; grant still held for H cycles
    apply_reset();
    bus.req = 3'b001;
    tick("drop");
    bus.req = 3'b101;
    tick("drop");
    bus.req = 3'b100;
    for (int i = 3; i <= H + 1; i++) begin
      tick("drop");
      chk("drop.pattern", 32'(bus.grant), (i <= H) ? 32'h1 : 32'h4);
    end

    // 5 paused cycles extend a grant to H+5 cycles
    apply_reset();
    bus.req = 3'b011;
    for (int i = 1; i <= H + 6; i++) begin
      bus.pause = (i >= 2 && i <= 6);
      tick("pause");
      chk("pause.pattern", 32'(bus.grant), (i <= H + 5) ? 32'h1 : 32'h2);
    end
    bus.pause = 1'b0;

    // release to idle, then round-robin resumes after the released index
    apply_reset();
    bus.req = 3'b010;
    tick("idle");
    bus.req = 3'b000;
    for (int i = 2; i <= H + 1; i++) tick("idle");
    chk("idle.grant", 32'(bus.grant), 32'h0);
    chk("idle.hex3", 32'(bus.HEX3), 32'hFF);
    bus.req = 3'b111;
    tick("resume");
    chk("resume.grant", 32'(bus.grant), 32'h4);

    // randomized run with live data changes
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.req = 3'($urandom_range(0, 7));
      bus.pause = ($urandom_range(0, 7) == 0);
      bus.data0 = 24'($urandom);
      bus.data1 = 24'($urandom);
      bus.data2 = 24'($urandom);
      bus.dp    = 6'($urandom_range(0, 63));
      tick("rand");
      chk("rand.onehot", 32'($countones(bus.grant) <= 1), 32'h1);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
